nios_mtl_sysid_ext: RTL and testbench
=====================================

# nios_mtl_sysid_ext

Parametrised system-ID peripheral on the Nios II Avalon-MM bus. Extends the fixed ID/timestamp slave with a registered read path, a free-running 64-bit uptime counter with coherent two-word reads, a software scratch register and a sticky status register. Software reads it at boot to confirm the loaded hardware matches the compiled BSP, and at run time as a monotonic time base.

## Interface
Parameters:
- SYSTEM_ID, 32'h5A0F_0001, constant returned at offset 0.
- TIMESTAMP, 32'd1460600513, build timestamp returned at offset 1.
- UPTIME_WIDTH, 64, uptime counter width; legal range 33..64; upper bits of the high word read 0.
- SCRATCH_RESET, 32'h0000_0000, reset value of the scratch register.

Ports:
- clock  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word offset.
- read  in  1  read strobe, single-cycle.
- write  in  1  write strobe, single-cycle.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high for one cycle when readdata is valid.

## Operation
Register map (word offsets):
- 0 ID: read-only, SYSTEM_ID.
- 1 TS: read-only, TIMESTAMP.
- 2 UPLO: reads counter[31:0] and, in the same cycle, copies counter[UPTIME_WIDTH-1:32] into the high shadow. Any write clears the counter to 0.
- 3 UPHI: reads the high shadow, not the live counter.
- 4 SCRATCH: read/write; byte lanes honour byteenable.
- 5 STATUS: bit0 OVF is sticky and set when the counter wraps from all-ones to 0; writing 1 to bit0 clears it. Bits [15:8] read UPTIME_WIDTH. Bit 16 reads 1 when the uptime feature is compiled in. All other bits read 0.
- 6, 7: read 0; writes are ignored.

Other rules:
- Writes to read-only offsets are ignored.
- The counter increments by 1 every clock unless it is being cleared.
- Read and write asserted in the same cycle: the write takes effect and the read is also served. The read returns the pre-write value.

## Timing
- Reset values: readdata = 0, readdatavalid = 0, counter = 0, shadow = 0, OVF = 0, scratch = SCRATCH_RESET.
- Read latency is fixed at 1. readdatavalid is asserted on the cycle after read, and readdata holds the sampled value for that cycle.
- There is no waitrequest. Back-to-back reads on every cycle are supported.
- After readdatavalid deasserts, readdata holds its last value.
- Write effect is visible on the next cycle. A read of UPLO on the cycle after a UPLO write returns 0.
- Clearing and wrapping in the same cycle: the clear wins and OVF is not set.
- A wrap and an OVF clear write in the same cycle: the set wins, so OVF = 1.
- Reset asserted mid-read: readdatavalid drops asynchronously and the pending read is lost.

## Configuration
- SYSID_UPTIME_EN defined: the uptime counter, shadow and OVF logic are built.
- SYSID_UPTIME_EN not defined: none of that logic exists.
  - UPLO, UPHI and STATUS bit0 read 0, and STATUS bit16 reads 0.
  - Writes to UPLO have no effect.
  - STATUS[15:8] still reads UPTIME_WIDTH.
  - Read latency is unchanged.

## Structure
- Package nios_mtl_sysid_pkg holds:
  - register offset localparams (OFS_ID through OFS_STATUS),
  - STATUS bit positions,
  - the default SYSTEM_ID constant.
- Sub-module nios_mtl_sysid_uptime holds the counter, shadow capture, clear and OVF generation.
  - Inputs: capture, clear, ovf_clr.
  - Outputs: lo, hi_shadow, ovf.
  - It is instantiated only under SYSID_UPTIME_EN.
- The top level contains the address decode, scratch register and registered read mux.

## Test plan
- Reset, then read offsets 0 and 1: readdata = SYSTEM_ID and then 1460600513, each with readdatavalid exactly 1 cycle after read.
- Write 32'hAABB_CCDD with byteenable 4'b0101 to SCRATCH (reset value 0), then read back: 32'h00BB_00DD.
- Force the counter to 64'h0000_0000_FFFF_FFFE, wait 1 cycle, read UPLO, then read UPHI 5 cycles later: UPLO = FFFF_FFFF and UPHI = 0, because the shadow is captured at the UPLO read.
- Force the counter to all-ones: OVF = 1 after the wrap. Write STATUS = 1: OVF = 0. Repeat with a UPLO clear in the wrap cycle: OVF stays 0.
- Issue reads on 8 consecutive cycles over offsets 0..7: 8 consecutive readdatavalid pulses, and offsets 6 and 7 return 0.
- Build without SYSID_UPTIME_EN: UPLO and UPHI read 0 and STATUS reads 32'h0000_4000.

Source files
------------

// File: rtl/nios_mtl_sysid_pkg.sv
// -----------------------------------------------------------------------------
// nios_mtl_sysid_pkg
//
// Shared definitions for the extended system-ID peripheral:
//   - word offsets of the Avalon-MM register map
//   - bit positions inside the STATUS register
//   - the default SYSTEM_ID constant
//   - small helpers for byte-lane merging and STATUS word assembly
// -----------------------------------------------------------------------------
package nios_mtl_sysid_pkg;

   // Register map, word offsets
   localparam logic [2:0] OFS_ID      = 3'd0;
   localparam logic [2:0] OFS_TS      = 3'd1;
   localparam logic [2:0] OFS_UPLO    = 3'd2;
   localparam logic [2:0] OFS_UPHI    = 3'd3;
   localparam logic [2:0] OFS_SCRATCH = 3'd4;
   localparam logic [2:0] OFS_STATUS  = 3'd5;

   // STATUS register layout
   localparam int unsigned STATUS_OVF_BIT   = 0;
   localparam int unsigned STATUS_WIDTH_LSB = 8;
   localparam int unsigned STATUS_WIDTH_MSB = 15;
   localparam int unsigned STATUS_UPEN_BIT  = 16;

   localparam logic [31:0] SYSID_DEFAULT = 32'h5A0F_0001;

   // Replace only the byte lanes selected by be.
   function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            r[8*i +: 8] = wdata[8*i +: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] status_pack(input logic [7:0] width,
                                               input logic       upen,
                                               input logic       ovf);
      logic [31:0] r;
      r = '0;
      r[STATUS_OVF_BIT]                    = ovf;
      r[STATUS_WIDTH_MSB:STATUS_WIDTH_LSB] = width;
      r[STATUS_UPEN_BIT]                   = upen;
      return r;
   endfunction

endpackage

// File: rtl/nios_mtl_sysid_uptime.sv
// -----------------------------------------------------------------------------
// nios_mtl_sysid_uptime
//
// Free-running uptime counter with a high-word shadow and sticky wrap flag.
//
// Ports:
//   clock      in   system clock
//   reset_n    in   asynchronous active-low reset
//   capture    in   copy counter[UPTIME_WIDTH-1:32] into the shadow this cycle
//   clear      in   load the counter with 0 instead of incrementing
//   ovf_clr    in   clear the sticky overflow flag
//   lo         out  live counter[31:0]
//   hi_shadow  out  shadowed high word, zero-extended to 32 bits
//   ovf        out  sticky wrap flag
//
// UPTIME_WIDTH must lie in 33..64.
// -----------------------------------------------------------------------------
module nios_mtl_sysid_uptime #(
   parameter int unsigned UPTIME_WIDTH = 64
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        capture,
   input  logic        clear,
   input  logic        ovf_clr,
   output logic [31:0] lo,
   output logic [31:0] hi_shadow,
   output logic        ovf
);

   localparam int unsigned HiWidth = UPTIME_WIDTH - 32;

   logic [UPTIME_WIDTH-1:0] cnt_q, cnt_d;
   logic [HiWidth-1:0]      shadow_q, shadow_d;
   logic                    ovf_q, ovf_d;
   logic                    wrap;

   always_comb begin
      cnt_d    = cnt_q + UPTIME_WIDTH'(1);
      shadow_d = shadow_q;
      ovf_d    = ovf_q;
      // A clear in the wrap cycle suppresses the wrap.
      wrap     = (&cnt_q) & ~clear;

      if (clear) begin
         cnt_d = '0;
      end

      // Shadow takes the pre-increment value, coherent with lo read this cycle.
      if (capture) begin
         shadow_d = cnt_q[UPTIME_WIDTH-1:32];
      end

      // Set has priority over a software clear in the same cycle.
      if (wrap) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         shadow_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign lo        = cnt_q[31:0];
   assign hi_shadow = 32'(shadow_q);
   assign ovf       = ovf_q;

endmodule

// File: rtl/nios_mtl_sysid_ext.sv
// -----------------------------------------------------------------------------
// nios_mtl_sysid_ext
//
// Extended Avalon-MM system-ID slave: fixed ID and build timestamp, optional
// 64-bit (parametrisable) uptime counter with coherent two-word reads, a
// byte-writable scratch register and a STATUS register. Reads have a fixed
// latency of one clock and no waitrequest.
//
// Build option: define SYSID_UPTIME_EN to include the uptime counter, its
// high-word shadow and the OVF flag. Without it UPLO/UPHI and STATUS bits 0
// and 16 read 0 and UPLO writes do nothing.
//
// Ports:
//   clock          in   system clock
//   reset_n        in   asynchronous active-low reset
//   address[2:0]   in   word offset
//   read           in   single-cycle read strobe
//   write          in   single-cycle write strobe
//   writedata[31:0] in  write data
//   byteenable[3:0] in  write byte lanes
//   readdata[31:0] out  registered read data, held between reads
//   readdatavalid  out  one-cycle pulse, one clock after read
// -----------------------------------------------------------------------------
module nios_mtl_sysid_ext
   import nios_mtl_sysid_pkg::*;
#(
   parameter logic [31:0] SYSTEM_ID     = SYSID_DEFAULT,
   parameter logic [31:0] TIMESTAMP     = 32'd1460600513,
   parameter int unsigned UPTIME_WIDTH  = 64,
   parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic        readdatavalid
);

   logic [31:0] readdata_q, readdata_d;
   logic        rdv_q, rdv_d;
   logic [31:0] scratch_q, scratch_d;
   logic [31:0] rd_word;

   logic [31:0] uptime_lo;
   logic [31:0] uptime_hi;
   logic        uptime_ovf;
   logic        uptime_en;

`ifdef SYSID_UPTIME_EN
   logic up_capture;
   logic up_clear;
   logic up_ovf_clr;

   always_comb begin
      up_capture = read  & (address == OFS_UPLO);
      up_clear   = write & (address == OFS_UPLO);
      up_ovf_clr = write & (address == OFS_STATUS) & byteenable[0]
                   & writedata[STATUS_OVF_BIT];
   end

   nios_mtl_sysid_uptime #(
      .UPTIME_WIDTH (UPTIME_WIDTH)
   ) u_uptime (
      .clock     (clock),
      .reset_n   (reset_n),
      .capture   (up_capture),
      .clear     (up_clear),
      .ovf_clr   (up_ovf_clr),
      .lo        (uptime_lo),
      .hi_shadow (uptime_hi),
      .ovf       (uptime_ovf)
   );

   assign uptime_en = 1'b1;
`else
   assign uptime_lo  = '0;
   assign uptime_hi  = '0;
   assign uptime_ovf = 1'b0;
   assign uptime_en  = 1'b0;
`endif

   // Read mux works on current register values, so a read coinciding with a
   // write returns the pre-write contents.
   always_comb begin
      rd_word = '0;
      unique case (address)
         OFS_ID:      rd_word = SYSTEM_ID;
         OFS_TS:      rd_word = TIMESTAMP;
         OFS_UPLO:    rd_word = uptime_lo;
         OFS_UPHI:    rd_word = uptime_hi;
         OFS_SCRATCH: rd_word = scratch_q;
         OFS_STATUS:  rd_word = status_pack(8'(UPTIME_WIDTH), uptime_en, uptime_ovf);
         default:     rd_word = '0;
      endcase
   end

   always_comb begin
      readdata_d = readdata_q;
      rdv_d      = read;
      scratch_d  = scratch_q;

      if (read) begin
         readdata_d = rd_word;
      end

      if (write && (address == OFS_SCRATCH)) begin
         scratch_d = be_merge(scratch_q, writedata, byteenable);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         readdata_q <= '0;
         rdv_q      <= 1'b0;
         scratch_q  <= SCRATCH_RESET;
      end else begin
         readdata_q <= readdata_d;
         rdv_q      <= rdv_d;
         scratch_q  <= scratch_d;
      end
   end

   assign readdata      = readdata_q;
   assign readdatavalid = rdv_q;

endmodule

// File: tb/tb_nios_mtl_sysid_ext.sv
module tb_nios_mtl_sysid_ext;

   localparam logic [31:0] EXP_ID = 32'h5A0F_0001;
   localparam logic [31:0] EXP_TS = 32'd1460600513;
`ifdef SYSID_UPTIME_EN
   localparam logic [31:0] EXP_STATUS = 32'h0001_4000;
`else
   localparam logic [31:0] EXP_STATUS = 32'h0000_4000;
`endif

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic [3:0]  byteenable = '0;
   logic [31:0] readdata;
   logic        readdatavalid;

   nios_mtl_sysid_ext dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .address       (address),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .byteenable    (byteenable),
      .readdata      (readdata),
      .readdatavalid (readdatavalid)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] data;
      int unsigned cyc;
      string       name;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned cycle_cnt = 0;
   int          checks = 0;
   int          errors = 0;

   always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: every readdatavalid pulse must match the oldest queued read and
   // arrive exactly one cycle after it was issued.
   always @(negedge clock) begin
      if (reset_n && readdatavalid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got readdata %h, expected no response", readdata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, readdata, e.data);
            check({e.name, "_latency"}, cycle_cnt, e.cyc + 1);
         end
      end
   end

   // All stimulus tasks start and end at a falling edge.
   task automatic push_exp(input logic [31:0] d, input string nm);
      exp_t e;
      e.data = d;
      e.cyc  = cycle_cnt;
      e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] d, input string nm);
      address = a;
      read    = 1'b1;
      push_exp(d, nm);
      @(negedge clock);
      read = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
      address    = a;
      write      = 1'b1;
      writedata  = d;
      byteenable = be;
      @(negedge clock);
      write = 1'b0;
   endtask

   task automatic rw(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be,
                     input logic [31:0] exp_rd, input string nm);
      address    = a;
      read       = 1'b1;
      write      = 1'b1;
      writedata  = d;
      byteenable = be;
      push_exp(exp_rd, nm);
      @(negedge clock);
      read  = 1'b0;
      write = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      logic [31:0] sweep_exp [8];
`ifdef SYSID_UPTIME_EN
      int unsigned clr_cyc;
      int unsigned wrap_cyc;
`endif

      // Reset state
      idle(3);
      check("reset_readdata", readdata, 32'h0);
      check("reset_valid", {31'h0, readdatavalid}, 32'h0);
      reset_n = 1'b1;
      idle(2);

      // Fixed identity words
      rd(3'd0, EXP_ID, "id");
      rd(3'd1, EXP_TS, "ts");

      // Scratch: reset value, byte lanes
      rd(3'd4, 32'h0, "scratch_reset");
      wr(3'd4, 32'hAABB_CCDD, 4'b0101);
      rd(3'd4, 32'h00BB_00DD, "scratch_be0101");

      // Writes to read-only and unmapped offsets are ignored
      wr(3'd0, 32'hFFFF_FFFF, 4'hF);
      wr(3'd1, 32'h0, 4'hF);
      wr(3'd6, 32'h1234_5678, 4'hF);
      rd(3'd0, EXP_ID, "id_after_write");
      rd(3'd1, EXP_TS, "ts_after_write");
      rd(3'd6, 32'h0, "ofs6_after_write");

      // Read and write together: read sees pre-write value
      rw(3'd4, 32'h1234_5678, 4'b1111, 32'h00BB_00DD, "scratch_rw_pre");
      rd(3'd4, 32'h1234_5678, "scratch_rw_post");

      // readdata holds after readdatavalid drops
      idle(3);
      check("hold_readdata", readdata, 32'h1234_5678);
      check("hold_valid_low", {31'h0, readdatavalid}, 32'h0);

`ifdef SYSID_UPTIME_EN
      // UPLO write clears; read on the next cycle returns 0
      wr(3'd2, 32'h0, 4'hF);
      rd(3'd2, 32'h0, "uplo_after_clear");

      // Shadow captured at UPLO read, not at UPHI read
      force dut.u_uptime.cnt_q = 64'h0000_0000_FFFF_FFFE;
      #1 release dut.u_uptime.cnt_q;
      idle(1);
      wrap_cyc = cycle_cnt;
      rd(3'd2, 32'hFFFF_FFFF, "uplo_ffffffff");
      idle(4);
      rd(3'd3, 32'h0, "uphi_shadow_old");
      // Counter is now past 2^32; a fresh UPLO read captures high word 1
      rd(3'd2, cycle_cnt - wrap_cyc - 1, "uplo_after_carry");
      rd(3'd3, 32'h1, "uphi_shadow_new");

      // Wrap sets OVF; writing 1 clears it
      force dut.u_uptime.cnt_q = '1;
      #1 release dut.u_uptime.cnt_q;
      idle(1);
      rd(3'd5, EXP_STATUS | 32'h1, "status_ovf_set");
      wr(3'd5, 32'h1, 4'hF);
      rd(3'd5, EXP_STATUS, "status_ovf_cleared");

      // Clear in the wrap cycle: clear wins, no OVF
      force dut.u_uptime.cnt_q = '1;
      address    = 3'd2;
      write      = 1'b1;
      writedata  = 32'h0;
      byteenable = 4'hF;
      #1 release dut.u_uptime.cnt_q;
      @(negedge clock);
      write = 1'b0;
      rd(3'd2, 32'h0, "uplo_clear_beats_wrap");
      rd(3'd5, EXP_STATUS, "status_clear_beats_wrap");

      // OVF clear in the wrap cycle: set wins
      force dut.u_uptime.cnt_q = '1;
      address    = 3'd5;
      write      = 1'b1;
      writedata  = 32'h1;
      byteenable = 4'hF;
      #1 release dut.u_uptime.cnt_q;
      @(negedge clock);
      write = 1'b0;
      rd(3'd5, EXP_STATUS | 32'h1, "status_set_beats_clr");
      wr(3'd5, 32'h1, 4'hF);

      // Known counter origin for the sweep below
      wr(3'd2, 32'h0, 4'hF);
      clr_cyc = cycle_cnt - 1;
`else
      // Without the uptime feature UPLO/UPHI read 0 and writes do nothing
      wr(3'd2, 32'hFFFF_FFFF, 4'hF);
      rd(3'd2, 32'h0, "uplo_disabled");
      rd(3'd3, 32'h0, "uphi_disabled");
      wr(3'd5, 32'hFFFF_FFFF, 4'hF);
      rd(3'd5, EXP_STATUS, "status_disabled");
`endif

      // Back-to-back reads over every offset
      sweep_exp[0] = EXP_ID;
      sweep_exp[1] = EXP_TS;
      sweep_exp[2] = 32'h0;
      sweep_exp[3] = 32'h0;
      sweep_exp[4] = 32'h1234_5678;
      sweep_exp[5] = EXP_STATUS;
      sweep_exp[6] = 32'h0;
      sweep_exp[7] = 32'h0;
      for (int i = 0; i < 8; i++) begin
`ifdef SYSID_UPTIME_EN
         if (i == 2) sweep_exp[2] = cycle_cnt - clr_cyc - 1;
`endif
         rd(3'(i), sweep_exp[i], $sformatf("sweep_ofs%0d", i));
      end

      // Reset during a pending read: valid drops immediately, response lost
      idle(2);
      address = 3'd0;
      read    = 1'b1;
      @(posedge clock);
      #1;
      read    = 1'b0;
      reset_n = 1'b0;
      #1;
      check("reset_mid_read_valid", {31'h0, readdatavalid}, 32'h0);
      check("reset_mid_read_data", readdata, 32'h0);
      @(negedge clock);
      idle(1);
      reset_n = 1'b1;
      idle(1);
      rd(3'd4, 32'h0, "scratch_after_reset");

      // Every issued read must have been answered
      idle(3);
      check("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end of test, expected completion");
      $fatal(1, "timeout");
   end

endmodule
